// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point divide stream.
// Contents:
//   div_tag_t     sideband carried alongside the divider pipeline
//   fxp_div_lat   pipeline depth of pipe_FixedPointDiv for a given quotient format
//   fxp_sat_max   most positive two's-complement code of a w-bit word
//   fxp_sat_min   most negative two's-complement code of a w-bit word
package fxp_pkg;

   typedef struct packed {
      logic vld;    // slot holds an accepted operand pair
      logic dz;     // divisor was exactly zero
      logic dsgn;   // dividend sign, picks the saturation direction on divide-by-zero
   } div_tag_t;

   function automatic int fxp_div_lat(input int woi, input int wof);
      return woi + wof + 3;
   endfunction

   function automatic logic [63:0] fxp_sat_max(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] fxp_sat_min(input int w);
      return 64'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/fxp_div_stream_div.sv
// pipe_FixedPointDiv: fixed-latency signed fixed-point divider, no stall.
// A new operand pair may be presented every cycle; its result appears on
// quot/overflow exactly fxp_div_lat(WOI, WOF) clock edges later.
// Arithmetic: sign-magnitude restoring division producing one extra
// quotient bit below the LSB, then round-half-away-from-zero (ROUND=1)
// or truncate toward zero (ROUND=0), then saturate to the output format.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   dividend      signed Q(WIIA).(WIFA)
//   divisor       signed Q(WIIB).(WIFB)
//   quot          signed Q(WOI).(WOF)
//   overflow      quotient saturated (a zero divisor always lands here too)
module pipe_FixedPointDiv
   import fxp_pkg::*;
#(
   parameter int WIIA  = 8,
   parameter int WIFA  = 8,
   parameter int WIIB  = 8,
   parameter int WIFB  = 8,
   parameter int WOI   = 8,
   parameter int WOF   = 8,
   parameter int ROUND = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIIA+WIFA-1:0]   dividend,
   input  logic [WIIB+WIFB-1:0]   divisor,
   output logic [WOI+WOF-1:0]     quot,
   output logic                   overflow
);

   localparam int WA = WIIA + WIFA;
   localparam int WB = WIIB + WIFB;
   localparam int W  = WOI + WOF;
   // quotient LSB weight relative to dividend/divisor LSB weights
   localparam int S  = WOF - WIFA + WIFB;
   localparam int SP = (S < 0) ? 0 : S;
   // one iteration per quotient bit plus the rounding bit
   localparam int NS = W + 1;
   localparam int RW = WA + SP + WB + W + 2;

   localparam logic [W-1:0] Q_MAX   = W'(fxp_sat_max(W));
   localparam logic [W-1:0] Q_MIN   = W'(fxp_sat_min(W));
   localparam logic [W:0]   POS_LIM = {1'b0, Q_MAX};
   localparam logic [W:0]   NEG_LIM = {1'b0, Q_MIN};

   if (S < 0) begin : g_fmt_chk
      $error("pipe_FixedPointDiv: WOF - WIFA + WIFB must be >= 0");
   end

   logic [WA-1:0] a_mag;
   logic [WB-1:0] b_mag;
   logic [RW-1:0] rem_init;
   logic          ovf_init;

   logic [RW-1:0] rem_q [0:NS];
   logic [WB-1:0] den_q [0:NS];
   logic [W:0]    quo_q [0:NS];
   logic          neg_q [0:NS];
   logic          ovf_q [0:NS];

   logic [RW-1:0] rem_n [1:NS];
   logic [W:0]    quo_n [1:NS];

   logic [W-1:0]  q_half;
   logic          round_bit;
   logic [W:0]    mag;
   logic          ovf_n;
   logic [W-1:0]  quot_n;

   // Remainder starts as 2*|a|*2^S so the last iteration yields the bit
   // just below the quotient LSB. If the quotient cannot fit in W+1 bits
   // it is flagged here and the iterations' output is ignored.
   always_comb begin
      a_mag    = dividend[WA-1] ? (~dividend + WA'(1)) : dividend;
      b_mag    = divisor[WB-1]  ? (~divisor  + WB'(1)) : divisor;
      rem_init = RW'(a_mag) << (SP + 1);
      ovf_init = rem_init >= (RW'(b_mag) << (W + 1));
   end

   always_comb begin
      for (int k = 1; k <= NS; k++) begin
         rem_n[k] = rem_q[k-1];
         quo_n[k] = {quo_q[k-1][W-1:0], 1'b0};
         if (rem_q[k-1] >= (RW'(den_q[k-1]) << (NS - k))) begin
            rem_n[k]    = rem_q[k-1] - (RW'(den_q[k-1]) << (NS - k));
            quo_n[k][0] = 1'b1;
         end
      end
   end

   // quo_q[NS] = floor(2*|a|/|b|); rounding adds its LSB back to the half.
   always_comb begin
      q_half    = quo_q[NS][W:1];
      round_bit = (ROUND != 0) & quo_q[NS][0];
      mag       = {1'b0, q_half} + {{W{1'b0}}, round_bit};
      ovf_n     = ovf_q[NS] | (neg_q[NS] ? (mag > NEG_LIM) : (mag > POS_LIM));
      if (ovf_n) begin
         quot_n = neg_q[NS] ? Q_MIN : Q_MAX;
      end else begin
         quot_n = neg_q[NS] ? (~mag[W-1:0] + W'(1)) : mag[W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k <= NS; k++) begin
            rem_q[k] <= '0;
            den_q[k] <= '0;
            quo_q[k] <= '0;
            neg_q[k] <= 1'b0;
            ovf_q[k] <= 1'b0;
         end
         quot     <= '0;
         overflow <= 1'b0;
      end else begin
         rem_q[0] <= rem_init;
         den_q[0] <= b_mag;
         quo_q[0] <= '0;
         neg_q[0] <= dividend[WA-1] ^ divisor[WB-1];
         ovf_q[0] <= ovf_init;
         for (int k = 1; k <= NS; k++) begin
            rem_q[k] <= rem_n[k];
            den_q[k] <= den_q[k-1];
            quo_q[k] <= quo_n[k];
            neg_q[k] <= neg_q[k-1];
            ovf_q[k] <= ovf_q[k-1];
         end
         quot     <= quot_n;
         overflow <= ovf_n;
      end
   end

endmodule

// File: rtl/fxp_div_stream.sv
// fxp_div_stream: valid/ready wrapper around pipe_FixedPointDiv.
// Operands are admitted only while a result slot is guaranteed (occ counts
// items in flight plus items queued), so the divider never stalls and the
// output FIFO can never overflow. Divide-by-zero is detected at the input,
// carried alongside the pipeline and overrides the divider result.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   in_valid/in_ready                operand handshake
//   in_dividend, in_divisor          signed operands
//   out_valid/out_ready              result handshake (show-ahead FIFO head)
//   out_quot, out_overflow, out_divzero   result fields, zero while out_valid=0
module fxp_div_stream
   import fxp_pkg::*;
#(
   parameter int WIIA  = 8,
   parameter int WIFA  = 8,
   parameter int WIIB  = 8,
   parameter int WIFB  = 8,
   parameter int WOI   = 8,
   parameter int WOF   = 8,
   parameter int ROUND = 1,
   parameter int DEPTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIIA+WIFA-1:0]   in_dividend,
   input  logic [WIIB+WIFB-1:0]   in_divisor,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WOI+WOF-1:0]     out_quot,
   output logic                   out_overflow,
   output logic                   out_divzero
);

   localparam int WA  = WIIA + WIFA;
   localparam int W   = WOI + WOF;
   localparam int LAT = fxp_div_lat(WOI, WOF);
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1;

   localparam logic [W-1:0] Q_MAX = W'(fxp_sat_max(W));
   localparam logic [W-1:0] Q_MIN = W'(fxp_sat_min(W));

   if (DEPTH < 1) begin : g_depth_chk
      $error("fxp_div_stream: DEPTH must be >= 1");
   end

   typedef struct packed {
      logic         ovf;
      logic         dz;
      logic [W-1:0] quot;
   } fifo_entry_t;

   logic                 accept;
   logic                 pop;
   logic                 fifo_wr;
   logic [CW-1:0]        occ;
   logic [CW-1:0]        count;
   logic [PW-1:0]        wptr;
   logic [PW-1:0]        rptr;
   div_tag_t [LAT-1:0]   tag_q;
   div_tag_t             tail;
   logic [W-1:0]         div_quot;
   logic                 div_ovf;
   fifo_entry_t          wr_entry;
   fifo_entry_t          head;
   fifo_entry_t          mem [0:DEPTH-1];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign in_ready  = (occ < CW'(DEPTH));
   assign accept    = in_valid & in_ready;
   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ <= '0;
      end else if (accept & ~pop) begin
         occ <= occ + CW'(1);
      end else if (pop & ~accept) begin
         occ <= occ - CW'(1);
      end
   end

   // The divider sees the input bus every cycle; the tag pipe decides
   // which of its results are real.
   pipe_FixedPointDiv #(
      .WIIA  (WIIA),
      .WIFA  (WIFA),
      .WIIB  (WIIB),
      .WIFB  (WIFB),
      .WOI   (WOI),
      .WOF   (WOF),
      .ROUND (ROUND)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .dividend (in_dividend),
      .divisor  (in_divisor),
      .quot     (div_quot),
      .overflow (div_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_q <= '0;
      end else begin
         tag_q[0] <= '{vld: accept, dz: (in_divisor == '0), dsgn: in_dividend[WA-1]};
         for (int k = 1; k < LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
      end
   end

   assign tail    = tag_q[LAT-1];
   assign fifo_wr = tail.vld;

   // A zero divisor saturates toward the dividend's sign, including 0/0.
   always_comb begin
      wr_entry.ovf  = div_ovf;
      wr_entry.dz   = 1'b0;
      wr_entry.quot = div_quot;
      if (tail.dz) begin
         wr_entry.ovf  = 1'b1;
         wr_entry.dz   = 1'b1;
         wr_entry.quot = tail.dsgn ? Q_MIN : Q_MAX;
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         mem[wptr] <= wr_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (fifo_wr) begin
            wptr <= ptr_inc(wptr);
         end
         if (pop) begin
            rptr <= ptr_inc(rptr);
         end
         if (fifo_wr & ~pop) begin
            count <= count + CW'(1);
         end else if (pop & ~fifo_wr) begin
            count <= count - CW'(1);
         end
      end
   end

   // Gate with out_valid so an empty FIFO shows zeros, not stale memory.
   assign head         = mem[rptr];
   assign out_quot     = out_valid ? head.quot : '0;
   assign out_overflow = out_valid & head.ovf;
   assign out_divzero  = out_valid & head.dz;

`ifndef SYNTHESIS
   a_no_write_when_full : assert property (@(posedge clk) disable iff (rst)
      !(fifo_wr && (count == CW'(DEPTH))));
`endif

endmodule

// File: tb/tb_fxp_div_stream.sv
module tb_fxp_div_stream;

   localparam int WIIA  = 8;
   localparam int WIFA  = 8;
   localparam int WIIB  = 8;
   localparam int WIFB  = 8;
   localparam int WOI   = 8;
   localparam int WOF   = 8;
   localparam int ROUND = 1;
   localparam int DEPTH = 32;
   localparam int LAT   = WOI + WOF + 3;
   localparam int SHIFT = WOF - WIFA + WIFB;

   typedef logic [17:0] res_t;   // {ovf, dz, quot}

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_dividend;
   logic [15:0] in_divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_quot;
   logic        out_overflow;
   logic        out_divzero;

   int   checks = 0;
   int   passed = 0;
   res_t exp_q[$];

   always #5 clk = ~clk;

   fxp_div_stream #(
      .WIIA(WIIA), .WIFA(WIFA), .WIIB(WIIB), .WIFB(WIFB),
      .WOI(WOI), .WOF(WOF), .ROUND(ROUND), .DEPTH(DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_dividend  (in_dividend),
      .in_divisor   (in_divisor),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_quot     (out_quot),
      .out_overflow (out_overflow),
      .out_divzero  (out_divzero)
   );

   // Reference: exact rational quotient a/b scaled to the output format,
   // rounded half away from zero (or truncated), then saturated.
   function automatic res_t ref_div(input logic [15:0] a, input logic [15:0] b);
      longint num, den, na, nd, mag, val;
      if (b == 16'h0000) return {1'b1, 1'b1, (a[15] ? 16'h8000 : 16'h7FFF)};
      num = longint'($signed(a)) * (longint'(1) << SHIFT);
      den = longint'($signed(b));
      na  = (num < 0) ? -num : num;
      nd  = (den < 0) ? -den : den;
      if (ROUND != 0) mag = (2 * na + nd) / (2 * nd);
      else            mag = na / nd;
      val = ((num < 0) != (den < 0)) ? -mag : mag;
      if (val > 32767)  return {2'b10, 16'h7FFF};
      if (val < -32768) return {2'b10, 16'h8000};
      return {2'b00, val[15:0]};
   endfunction

   // Sends one pair into an idle block and waits for its result.
   task automatic run_single(input logic [15:0] a, input logic [15:0] b,
                             output res_t r, output int lat);
      @(negedge clk);
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      in_dividend = a;
      in_divisor  = b;
      @(negedge clk);
      in_valid = 1'b0;
      lat      = -1;
      r        = '0;
      for (int c = 1; c <= 3 * LAT; c++) begin
         if (out_valid) begin
            lat = c;
            r   = {out_overflow, out_divzero, out_quot};
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; in_dividend = '0; in_divisor = '0;
      repeat (3) @(negedge clk);
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
      checks++; if (out_quot !== 16'h0000) $display("FAIL reset_out_quot: got %h expected 0000", out_quot); else passed++;
      checks++; if (out_overflow !== 1'b0) $display("FAIL reset_out_overflow: got %b expected 0", out_overflow); else passed++;
      checks++; if (out_divzero !== 1'b0) $display("FAIL reset_out_divzero: got %b expected 0", out_divzero); else passed++;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [15:0] va [3] = '{16'h0300, 16'hFD00, 16'h6400};
      logic [15:0] vb [3] = '{16'h0200, 16'h0200, 16'h0080};
      res_t        ve [3] = '{{2'b00, 16'h0180}, {2'b00, 16'hFE80}, {2'b10, 16'h7FFF}};
      res_t r;
      int   lat;
      for (int i = 0; i < 3; i++) begin
         run_single(va[i], vb[i], r, lat);
         checks++; if (r !== ve[i]) $display("FAIL basic_result[%0d]: got %h expected %h", i, r, ve[i]); else passed++;
         checks++; if (lat !== LAT + 1) $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, lat, LAT + 1); else passed++;
      end
   endtask

   task automatic test_divzero();
      logic [15:0] va [3] = '{16'h0100, 16'hFF00, 16'h0000};
      res_t        ve [3] = '{{2'b11, 16'h7FFF}, {2'b11, 16'h8000}, {2'b11, 16'h7FFF}};
      res_t r;
      int   lat;
      for (int i = 0; i < 3; i++) begin
         run_single(va[i], 16'h0000, r, lat);
         checks++; if (r !== ve[i]) $display("FAIL divzero_result[%0d]: got %h expected %h", i, r, ve[i]); else passed++;
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] pa [40];
      logic [15:0] pb [40];
      logic [31:0] t1, t2;
      res_t exp_r, got;
      int idx = 0;
      int npop = 0;
      for (int i = 0; i < 40; i++) begin
         t1 = $urandom; t2 = $urandom;
         pa[i] = {t1[7:0], 8'(i)};
         pb[i] = t2[15:0];
      end
      exp_q.delete();
      @(negedge clk);
      out_ready = 1'b0;
      for (int c = 0; c < 60; c++) begin
         in_valid    = (idx < 40);
         in_dividend = pa[idx % 40];
         in_divisor  = pb[idx % 40];
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_div(pa[idx], pb[idx]));
            idx++;
         end
         @(negedge clk);
      end
      checks++; if (idx !== DEPTH) $display("FAIL bp_accept_count: got %0d expected %0d", idx, DEPTH); else passed++;
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); else passed++;
      out_ready = 1'b1;
      for (int d = 0; d < 200 && npop < 40; d++) begin
         if (d == 0) begin
            checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_at_first_pop: got %b expected 0", in_ready); else passed++;
         end
         if (d == 1) begin
            checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after_first_pop: got %b expected 1", in_ready); else passed++;
         end
         if (out_valid) begin
            got = {out_overflow, out_divzero, out_quot};
            exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
            checks++; if (got !== exp_r) $display("FAIL bp_result[%0d]: got %h expected %h", npop, got, exp_r); else passed++;
            npop++;
         end
         in_valid    = (idx < 40);
         in_dividend = pa[idx % 40];
         in_divisor  = pb[idx % 40];
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_div(pa[idx], pb[idx]));
            idx++;
         end
         @(negedge clk);
      end
      checks++; if (npop !== 40) $display("FAIL bp_pop_count: got %0d expected 40", npop); else passed++;
      in_valid = 1'b0;
   endtask

   task automatic test_streaming();
      localparam int N = 200;
      logic [15:0] sa [N];
      logic [15:0] sb [N];
      logic [31:0] t1, t2;
      res_t exp_r, got;
      int sent = 0, recv = 0, first = -1, gaps = 0, stalls = 0;
      for (int i = 0; i < N; i++) begin
         t1 = $urandom; t2 = $urandom;
         sa[i] = t1[15:0];
         case ($urandom_range(0, 9))
            0:       sb[i] = 16'h0000;
            1, 2:    sb[i] = t2[16] ? (16'h0000 - {8'h00, t2[7:0]}) : {8'h00, t2[7:0]};
            default: sb[i] = t2[15:0];
         endcase
      end
      exp_q.delete();
      @(negedge clk);
      out_ready = 1'b1;
      for (int c = 0; c < N + 3 * LAT; c++) begin
         if (out_valid) begin
            if (first < 0) first = c;
            got = {out_overflow, out_divzero, out_quot};
            exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
            checks++; if (got !== exp_r) $display("FAIL stream_result[%0d]: got %h expected %h (a=%h b=%h)", recv, got, exp_r, sa[recv], sb[recv]); else passed++;
            recv++;
         end else if (first >= 0 && recv < N) begin
            gaps++;
         end
         if (sent < N) begin
            in_valid    = 1'b1;
            in_dividend = sa[sent];
            in_divisor  = sb[sent];
            if (in_ready) begin
               exp_q.push_back(ref_div(sa[sent], sb[sent]));
               sent++;
            end else begin
               stalls++;
            end
         end else begin
            in_valid = 1'b0;
         end
         if (recv == N) break;
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++; if (recv !== N) $display("FAIL stream_count: got %0d expected %0d", recv, N); else passed++;
      checks++; if (first !== LAT + 1) $display("FAIL stream_first_latency: got %0d expected %0d", first, LAT + 1); else passed++;
      checks++; if (gaps !== 0) $display("FAIL stream_gaps: got %0d expected 0", gaps); else passed++;
      checks++; if (stalls !== 0) $display("FAIL stream_input_stalls: got %0d expected 0", stalls); else passed++;
   endtask

   task automatic test_reset_midflight();
      logic [31:0] t1;
      res_t r;
      int   lat;
      int   stale = 0;
      @(negedge clk);
      out_ready = 1'b0;
      for (int c = 0; c < 30; c++) begin
         t1 = $urandom;
         in_valid    = (c < 20);
         in_dividend = t1[15:0];
         in_divisor  = t1[31:16] | 16'h0001;
         if (c == 29) begin
            checks++; if (out_valid !== 1'b1) $display("FAIL mid_pre_reset_valid: got %b expected 1", out_valid); else passed++;
            #1 rst = 1'b1;
            #1;
            checks++; if (out_valid !== 1'b0) $display("FAIL mid_reset_out_valid: got %b expected 0", out_valid); else passed++;
            checks++; if (in_ready !== 1'b1) $display("FAIL mid_reset_in_ready: got %b expected 1", in_ready); else passed++;
            checks++; if (out_quot !== 16'h0000) $display("FAIL mid_reset_out_quot: got %h expected 0000", out_quot); else passed++;
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rst       = 1'b0;
      for (int c = 0; c < 2 * LAT; c++) begin
         if (out_valid) stale++;
         @(negedge clk);
      end
      checks++; if (stale !== 0) $display("FAIL mid_stale_results: got %0d expected 0", stale); else passed++;
      run_single(16'h0300, 16'h0200, r, lat);
      checks++; if (r !== {2'b00, 16'h0180}) $display("FAIL mid_recover_result: got %h expected 00180", r); else passed++;
      checks++; if (lat !== LAT + 1) $display("FAIL mid_recover_latency: got %0d expected %0d", lat, LAT + 1); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_divzero();
      test_backpressure();
      test_streaming();
      test_reset_midflight();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
      $fatal(1);
   end

endmodule
